// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between two requesters.
// Each operation is accepted in IDLE, executed for one EXEC cycle, then held in RESP until taken.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err,
    output logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_next;
    logic              rr_ptr;
    logic              grant;
    logic [OP_W-1:0]   op_reg;
    logic [DATA_W-1:0] src1_reg;
    logic [DATA_W-1:0] src2_reg;
    logic [DATA_W-1:0] result_reg;
    logic              err_reg;

    logic winner;
    logic accept;
    logic rsp_done;
    logic op_legal;

    // Exactly one bit set; an all-zero code is illegal as well.
    assign op_legal = (op_reg != '0) && ((op_reg & (op_reg - OP_W'(1))) == '0);

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        winner      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        alu_control = '0;
        busy        = (state != IDLE);

        if (req0_valid && req1_valid) winner = rr_ptr;
        else                          winner = req1_valid;

        // Ready is gated by reset so nothing handshakes while the block is held in reset.
        if (state == IDLE && resetn) begin
            req0_ready = req0_valid && !winner;
            req1_ready = req1_valid &&  winner;
        end
        if (state == EXEC && op_legal) alu_control = op_reg;
        if (state == RESP) begin
            rsp0_valid = !grant;
            rsp1_valid =  grant;
        end
    end

    assign accept      = req0_ready || req1_ready;
    assign rsp_done    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign alu_src1    = src1_reg;
    assign alu_src2    = src2_reg;
    assign rsp0_result = result_reg;
    assign rsp1_result = result_reg;
    assign rsp0_err    = err_reg;
    assign rsp1_err    = err_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr     <= 1'b0;
            grant      <= 1'b0;
            op_reg     <= '0;
            src1_reg   <= '0;
            src2_reg   <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                grant    <= winner;
                op_reg   <= winner ? req1_op   : req0_op;
                src1_reg <= winner ? req1_src1 : req0_src1;
                src2_reg <= winner ? req1_src2 : req0_src2;
            end
            if (state == EXEC) begin
                result_reg <= op_legal ? alu_result : '0;
                err_reg    <= !op_legal;
            end
            if (rsp_done) begin
                rr_ptr   <= ~grant;
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational 32-bit ALU between two requesters. The ALU takes a 12-bit one-hot alu_control.
- Each requester presents an operation through a valid/ready handshake.
- The block arbitrates round-robin, latches the operands, drives the ALU for one cycle and registers the result.
- The result returns on a per-requester valid/ready response channel.
- It sits between the issue logic of two lab-pipeline clients (e.g. the EXE stage and a debug/self-test port) and the existing alu instance.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed at 32; other values unsupported)
OP_W, 12, one-hot ALU control width
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OP_W  requester 0 one-hot ALU control
req0_src1  in  DATA_W  requester 0 operand 1
req0_src2  in  DATA_W  requester 0 operand 2
req1_valid, req1_ready, req1_op, req1_src1, req1_src2  same as requester 0, for requester 1
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_result  out  DATA_W  result to requester 0
rsp0_err  out  1  operation code was not one-hot
rsp1_valid, rsp1_ready, rsp1_result, rsp1_err  same as the requester 0 response, for requester 1
alu_control  out  OP_W  to ALU
alu_src1  out  DATA_W  to ALU
alu_src2  out  DATA_W  to ALU
alu_result  in  DATA_W  from ALU (combinational)
busy  out  1  state != IDLE
op_count  out  CNT_W  number of completed response handshakes

Behaviour:
- Reset (async, resetn=0) forces the following; any in-flight operation is dropped with no response:
  - state=IDLE, rr_ptr=0, grant=0
  - op/src/result/err regs=0
  - all ready/valid outputs 0, alu_control=0, alu_src1/2=0, busy=0, op_count=0
- State IDLE:
  - Winner selection: only one reqN_valid → that N wins; both valid → winner = rr_ptr.
  - reqN_ready = 1 combinationally for the winner only, and only in IDLE. Handshake completes that cycle.
  - On handshake: latch op/src1/src2 into regs, grant=N, go EXEC.
  - No valid → stay IDLE.
- State EXEC (exactly 1 cycle):
  - Legal op: alu_control=op_reg; result_reg <= alu_result; err_reg <= 0.
  - Illegal op (op_reg not exactly one bit set, including all-zero): alu_control stays 0; result_reg <= 0; err_reg <= 1.
  - Go RESP.
- State RESP:
  - rsp[grant]_valid=1, driving result_reg/err_reg; the other rsp_valid=0.
  - Hold all response fields stable until rsp[grant]_ready=1.
  - On handshake: rr_ptr <= ~grant, op_count++ (wraps at 2^CNT_W-1 → 0), go IDLE.
- alu_control=0 in every state except EXEC. alu_src1/2 always reflect the latched operand regs.
- rsp_result/rsp_err are the latched regs (0 until first completion).
- Latency: accept at edge T → EXEC cycle T+1 → rsp_valid high from cycle T+2.
- Throughput: one operation per 3 cycles minimum; no request is accepted while busy.
- Simultaneous events:
  - A new reqN_valid during EXEC/RESP waits; no ready is given.
  - rsp_ready high before rsp_valid has no effect.
  - A requester whose request is pending in IDLE with both valid is guaranteed service within one other transaction (round-robin fairness).
- Inputs req*_op/src may change after their handshake without affecting the in-flight operation.

Test Plan:
- Reset, then req0 add (op=12'b0000_0000_0001, 0x00001111, 0x00001111), rsp0_ready=1 -> req0_ready pulses 1 cycle; alu_control=0x001 for exactly one cycle; rsp0_valid at T+2 with rsp0_result=0x00002222, err=0; op_count=1.
- req0 and req1 both valid on the same cycle after reset (req0 sub 0x1111-0x2222, req1 xor 0x1111^0x1111) -> req0 served first, rsp0_result=0xFFFFEEEF; req1 then served, rsp1_result=0x00000000; op_count=2.
- Both requesters continuously valid for 6 transactions -> grants alternate 0,1,0,1,0,1; never two consecutive grants to the same requester.
- req1 op=12'b0000_0000_0011 (illegal) -> alu_control stays 0 throughout; rsp1_err=1, rsp1_result=0.
- rsp0_ready held low 5 cycles in RESP while req1_valid=1 -> rsp0_valid/result stable; req1_ready stays 0; req1 accepted the cycle after the rsp0 handshake.
- Assert resetn=0 asynchronously mid-EXEC -> all outputs 0 immediately (before next edge); no rsp_valid after release; op_count=0.
